// File: rtl/memory_read_ctrl.sv
// memory_read_ctrl
//   Takes a frame's head block index from the egress queue, then walks that
//   frame's chain of 64-byte blocks in packet memory. Each block is
//   {payload[495:0], footer[15:0]}, and its footer gives the index of the
//   next block plus an end-of-packet flag. The 62 payload bytes of every
//   block are streamed out one byte per beat. Each block index is returned
//   to the free list once its last byte has gone out.
//
// Optional feature: define MEM_RD_PREFETCH_EN to add a second block buffer.
//   With it, the read of the next block is issued while the current block is
//   still streaming, so consecutive blocks leave with no bubble between them.
//
// Ports
//   clk, rst                     clock and asynchronous active-high reset
//   frame_valid_i/_head_idx_i    head block index offered by the egress queue
//   frame_ready_o                high while idle and able to accept a head
//   mem_ready_i                  memory controller can take a read request
//   mem_re_o, mem_addr_o         read request (one cycle) and block index
//   mem_rvalid_i, mem_rdata_i    read return (latency of one cycle or more)
//   data_o/_valid_o/_begin_o/_end_o, data_ready_i   egress byte stream
//   fl_free_req_o, fl_free_block_idx_o               free-list return pulse
module memory_read_ctrl #(
    parameter int ADDR_W        = 10,
    parameter int BLOCK_BYTES   = 64,
    parameter int PAYLOAD_BYTES = 62,
    parameter int BLOCK_BITS    = 8 * BLOCK_BYTES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_valid_i,
    input  logic [ADDR_W-1:0]     frame_head_idx_i,
    output logic                  frame_ready_o,
    input  logic                  mem_ready_i,
    output logic                  mem_re_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    input  logic                  mem_rvalid_i,
    input  logic [BLOCK_BITS-1:0] mem_rdata_i,
    output logic [7:0]            data_o,
    output logic                  data_valid_o,
    output logic                  data_begin_o,
    output logic                  data_end_o,
    input  logic                  data_ready_i,
    output logic                  fl_free_req_o,
    output logic [ADDR_W-1:0]     fl_free_block_idx_o
);
    localparam int PAY_BITS = 8 * PAYLOAD_BYTES;
    localparam int CNT_W    = $clog2(PAYLOAD_BYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PAYLOAD_BYTES - 1);

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, STREAM} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   curr_idx;
    logic [ADDR_W-1:0]   next_idx;
    logic                eop;
    logic                head_blk;   // current block is the first of the frame
    logic [CNT_W-1:0]    byte_cnt;
    logic [PAY_BITS-1:0] pay;

    // Footer decode straight off the read bus.
    logic [PAY_BITS-1:0] rd_pay;
    logic [ADDR_W-1:0]   rd_next;
    logic                rd_eop;
    logic                unused_footer;
    assign rd_pay        = mem_rdata_i[BLOCK_BITS-1 -: PAY_BITS];
    assign rd_next       = mem_rdata_i[15 -: ADDR_W];
    assign rd_eop        = mem_rdata_i[15-ADDR_W];
    assign unused_footer = ^mem_rdata_i[14-ADDR_W:0];

    // Byte k sits in the top byte once the payload is shifted left by 8k.
    logic [PAY_BITS-1:0] pay_sh;
    logic                last;
    logic                rd_fire;
    assign pay_sh  = pay << {byte_cnt, 3'b000};
    assign last    = (byte_cnt == LAST_BYTE);
    assign rd_fire = (state == RD_REQ) && mem_ready_i;

    assign data_valid_o = (state == STREAM);
    assign data_o       = data_valid_o ? pay_sh[PAY_BITS-1 -: 8] : 8'h00;
    assign data_begin_o = data_valid_o && head_blk && (byte_cnt == '0);
    assign data_end_o   = data_valid_o && eop && last;

`ifdef MEM_RD_PREFETCH_EN
    logic [PAY_BITS-1:0] pf_pay;
    logic [ADDR_W-1:0]   pf_next;
    logic                pf_eop;
    logic                pf_pend;   // prefetch read outstanding
    logic                pf_valid;  // prefetch buffer holds the next block
    logic                pf_fire;
    // A prefetch is allowed only when no read is in flight and the spare
    // buffer is empty. That keeps at most one read outstanding.
    assign pf_fire    = (state == STREAM) && !eop && !pf_pend && !pf_valid && mem_ready_i;
    assign mem_re_o   = rd_fire || pf_fire;
    assign mem_addr_o = pf_fire ? next_idx : curr_idx;
`else
    assign mem_re_o   = rd_fire;
    assign mem_addr_o = curr_idx;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            curr_idx            <= '0;
            next_idx            <= '0;
            eop                 <= 1'b0;
            head_blk            <= 1'b0;
            byte_cnt            <= '0;
            pay                 <= '0;
            frame_ready_o       <= 1'b0;
            fl_free_req_o       <= 1'b0;
            fl_free_block_idx_o <= '0;
`ifdef MEM_RD_PREFETCH_EN
            pf_pay              <= '0;
            pf_next             <= '0;
            pf_eop              <= 1'b0;
            pf_pend             <= 1'b0;
            pf_valid            <= 1'b0;
`endif
        end else begin
            fl_free_req_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_valid_i && frame_ready_o) begin
                        curr_idx      <= frame_head_idx_i;
                        head_blk      <= 1'b1;
                        frame_ready_o <= 1'b0;
                        state         <= RD_REQ;
                    end else begin
                        frame_ready_o <= 1'b1;
                    end
                end
                RD_REQ: begin
                    if (mem_ready_i) state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (mem_rvalid_i) begin
                        pay      <= rd_pay;
                        next_idx <= rd_next;
                        eop      <= rd_eop;
                        byte_cnt <= '0;
                        state    <= STREAM;
`ifdef MEM_RD_PREFETCH_EN
                        pf_pend  <= 1'b0;
`endif
                    end
                end
                STREAM: begin
`ifdef MEM_RD_PREFETCH_EN
                    if (pf_fire) pf_pend <= 1'b1;
                    if (pf_pend && mem_rvalid_i) begin
                        pf_pay   <= rd_pay;
                        pf_next  <= rd_next;
                        pf_eop   <= rd_eop;
                        pf_pend  <= 1'b0;
                        pf_valid <= 1'b1;
                    end
`endif
                    if (data_ready_i) begin
                        if (!last) begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end else begin
                            fl_free_req_o       <= 1'b1;
                            fl_free_block_idx_o <= curr_idx;
                            head_blk            <= 1'b0;
                            if (eop) begin
                                state         <= IDLE;
                                frame_ready_o <= 1'b1;
                            end else begin
                                curr_idx <= next_idx;
`ifdef MEM_RD_PREFETCH_EN
                                byte_cnt <= '0;
                                if (pf_valid) begin
                                    // Swap in the prefetched block, so no bubble.
                                    pay      <= pf_pay;
                                    next_idx <= pf_next;
                                    eop      <= pf_eop;
                                    pf_valid <= 1'b0;
                                end else if (pf_pend && mem_rvalid_i) begin
                                    // Data lands on the switch cycle: take it directly.
                                    pay      <= rd_pay;
                                    next_idx <= rd_next;
                                    eop      <= rd_eop;
                                    pf_pend  <= 1'b0;
                                    pf_valid <= 1'b0;
                                end else if (pf_pend || pf_fire) begin
                                    state <= RD_WAIT;
                                end else begin
                                    state <= RD_REQ;
                                end
`else
                                state <= RD_REQ;
`endif
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_read_ctrl.sv
module tb_memory_read_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         frame_valid = 1'b0;
    logic [9:0]   frame_head_idx = '0;
    logic         frame_ready;
    logic         mem_ready = 1'b1;
    logic         mem_re;
    logic [9:0]   mem_addr;
    logic         mem_rvalid;
    logic [511:0] mem_rdata;
    logic [7:0]   data;
    logic         data_valid, data_begin, data_end;
    logic         data_ready = 1'b1;
    logic         fl_free_req;
    logic [9:0]   fl_free_idx;

    always #5 clk = ~clk;

    memory_read_ctrl dut (
        .clk(clk), .rst(rst),
        .frame_valid_i(frame_valid), .frame_head_idx_i(frame_head_idx), .frame_ready_o(frame_ready),
        .mem_ready_i(mem_ready), .mem_re_o(mem_re), .mem_addr_o(mem_addr),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .data_o(data), .data_valid_o(data_valid), .data_begin_o(data_begin), .data_end_o(data_end),
        .data_ready_i(data_ready),
        .fl_free_req_o(fl_free_req), .fl_free_block_idx_o(fl_free_idx)
    );

    typedef struct {
        logic [7:0] d;
        logic       b;
        logic       e;
    } beat_t;

    beat_t        exp_beats[$];
    int           exp_rd[$];
    int           exp_fr[$];
    int           checks = 0;
    int           passes = 0;
    int           cyc = 0;
    int           beats_seen = 0;
    int           stalls = 0;
    int           beat_cyc[0:511];
    int           lat = 2;
    bit           bp_mode = 1'b0;
    logic [511:0] mem_blk[0:1023];

    function automatic logic [7:0] pat(int b, int k);
        return 8'(k + 13 * b - 65);   // block 5 carries 0x00..0x3D
    endfunction

    always @(posedge clk) cyc++;

    // Memory model: rvalid arrives lat cycles after the request cycle.
    int           m_cnt;
    bit           m_pend;
    logic [9:0]   m_addr;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rvalid <= 1'b0;
            mem_rdata  <= '0;
            m_pend     <= 1'b0;
            m_cnt      <= 0;
            m_addr     <= '0;
        end else begin
            mem_rvalid <= 1'b0;
            if (mem_re && mem_ready) begin
                if (lat <= 1) begin
                    mem_rvalid <= 1'b1;
                    mem_rdata  <= mem_blk[mem_addr];
                end else begin
                    m_pend <= 1'b1;
                    m_cnt  <= lat - 1;
                    m_addr <= mem_addr;
                end
            end else if (m_pend) begin
                if (m_cnt == 1) begin
                    mem_rvalid <= 1'b1;
                    mem_rdata  <= mem_blk[m_addr];
                    m_pend     <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    // Sink ready: pattern 1-0-0-1 during the second block of a frame when enabled.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode && beats_seen >= 62) begin
                data_ready = (ph == 0 || ph == 3);
                ph = (ph + 1) % 4;
            end else begin
                data_ready = 1'b1;
            end
        end
    end

    // Scoreboard monitor: pops expected reads, beats and frees as the DUT produces them.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (data_valid === 1'b1 && data === prev_data) passes++;
                else $display("FAIL stall_hold: data=%h valid=%b, required data=%h valid=1", data, data_valid, prev_data);
            end
            prev_stall = data_valid && !data_ready;
            prev_data  = data;
            if (prev_stall) stalls++;
            if (mem_re && mem_ready) begin
                checks++;
                if (exp_rd.size() == 0) begin
                    $display("FAIL read_addr: unexpected read of %0d", mem_addr);
                end else begin
                    int a;
                    a = exp_rd.pop_front();
                    if (mem_addr === 10'(a)) passes++;
                    else $display("FAIL read_addr: got %0d, required %0d", mem_addr, a);
                end
            end
            if (data_valid && data_ready) begin
                checks++;
                if (exp_beats.size() == 0) begin
                    $display("FAIL beat: unexpected byte %h", data);
                end else begin
                    beat_t x;
                    x = exp_beats.pop_front();
                    if (data === x.d && data_begin === x.b && data_end === x.e) passes++;
                    else $display("FAIL beat %0d: got d=%h b=%b e=%b, required d=%h b=%b e=%b",
                                  beats_seen, data, data_begin, data_end, x.d, x.b, x.e);
                end
                beat_cyc[beats_seen % 512] = cyc;
                beats_seen++;
            end
            if (fl_free_req) begin
                checks++;
                if (exp_fr.size() == 0) begin
                    $display("FAIL free_idx: unexpected free of %0d", fl_free_idx);
                end else begin
                    int f;
                    f = exp_fr.pop_front();
                    if (fl_free_idx === 10'(f)) passes++;
                    else $display("FAIL free_idx: got %0d, required %0d", fl_free_idx, f);
                end
            end
        end
    end

    task automatic set_blk(input int idx, input int nxt, input bit eop);
        logic [495:0] p;
        for (int k = 0; k < 62; k++) p[495 - 8 * k -: 8] = pat(idx, k);
        mem_blk[idx] = {p, 10'(nxt), eop, 5'b0};
    endtask

    task automatic push_frame(input int blks[$]);
        beat_t bt;
        for (int i = 0; i < blks.size(); i++) begin
            exp_rd.push_back(blks[i]);
            exp_fr.push_back(blks[i]);
            for (int k = 0; k < 62; k++) begin
                bt.d = pat(blks[i], k);
                bt.b = (i == 0 && k == 0);
                bt.e = (i == blks.size() - 1 && k == 61);
                exp_beats.push_back(bt);
            end
        end
    endtask

    // Leaves the caller #1 after the accept edge.
    task automatic start_frame(input int head);
        int n;
        n = 0;
        while (frame_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (frame_ready === 1'b1) passes++;
        else $display("FAIL frame_ready_wait: ready=%b, required 1 within 50 cycles", frame_ready);
        frame_head_idx = 10'(head);
        frame_valid    = 1'b1;
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(exp_beats.size() == 0 && exp_fr.size() == 0 && frame_ready === 1'b1) && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (exp_beats.size() == 0 && exp_fr.size() == 0 && frame_ready === 1'b1) passes++;
        else $display("FAIL frame_done: beats left %0d frees left %0d ready=%b, required 0 0 1",
                      exp_beats.size(), exp_fr.size(), frame_ready);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({frame_ready, mem_re, mem_addr, data, data_valid, data_begin, data_end, fl_free_req, fl_free_idx} === '0) passes++;
        else $display("FAIL reset_outputs: some output nonzero (ready=%b re=%b valid=%b free=%b), required all 0",
                      frame_ready, mem_re, data_valid, fl_free_req);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (frame_ready === 1'b1) passes++;
        else $display("FAIL ready_after_reset: got %b, required 1", frame_ready);
    endtask

    task automatic test_single();
        int q[$];
        q = {5};
        set_blk(5, 0, 1'b1);
        beats_seen = 0;
        push_frame(q);
        start_frame(5);
        checks++;
        if (mem_re === 1'b1 && mem_addr === 10'd5) passes++;
        else $display("FAIL head_to_read: re=%b addr=%0d, required re=1 addr=5", mem_re, mem_addr);
        checks++;
        if (frame_ready === 1'b0) passes++;
        else $display("FAIL ready_busy: got %b, required 0", frame_ready);
        wait_idle(300);
        checks++;
        if (beats_seen == 62) passes++;
        else $display("FAIL single_beats: got %0d, required 62", beats_seen);
    endtask

    task automatic test_chain();
        int q[$];
        q = {3, 9, 1};
        set_blk(3, 9, 1'b0);
        set_blk(9, 1, 1'b0);
        set_blk(1, 0, 1'b1);
        beats_seen = 0;
        push_frame(q);
        start_frame(3);
        // A head offered while busy must be ignored.
        frame_head_idx = 10'd20;
        frame_valid    = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        frame_valid = 1'b0;
        wait_idle(800);
        checks++;
        if (beats_seen == 186) passes++;
        else $display("FAIL chain_beats: got %0d, required 186", beats_seen);
    endtask

    task automatic test_backpressure();
        int q[$];
        q = {4, 7};
        set_blk(4, 7, 1'b0);
        set_blk(7, 0, 1'b1);
        beats_seen = 0;
        stalls     = 0;
        bp_mode    = 1'b1;
        push_frame(q);
        start_frame(4);
        wait_idle(1000);
        bp_mode = 1'b0;
        checks++;
        if (beats_seen == 124) passes++;
        else $display("FAIL bp_beats: got %0d, required 124", beats_seen);
        checks++;
        if (stalls > 0) passes++;
        else $display("FAIL bp_stalls: got %0d stall cycles, required >0", stalls);
    endtask

    task automatic test_mem_stall();
        int q[$];
        int req_cyc, rv_cyc, n;
        q = {11};
        set_blk(11, 0, 1'b1);
        lat        = 7;
        mem_ready  = 1'b0;
        beats_seen = 0;
        push_frame(q);
        start_frame(11);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_re === 1'b0) passes++;
            else $display("FAIL no_read_unready: re=%b at stall cycle %0d, required 0", mem_re, i);
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b1;
        #1;
        req_cyc = cyc;
        checks++;
        if (mem_re === 1'b1 && mem_addr === 10'd11) passes++;
        else $display("FAIL read_on_ready: re=%b addr=%0d, required re=1 addr=11", mem_re, mem_addr);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mem_rvalid !== 1'b1 && n < 20);
        rv_cyc = cyc;
        checks++;
        if (mem_rvalid === 1'b1 && rv_cyc - req_cyc == 7) passes++;
        else $display("FAIL read_latency: rvalid=%b after %0d cycles, required 1 after 7", mem_rvalid, rv_cyc - req_cyc);
        checks++;
        if (data_valid === 1'b0) passes++;
        else $display("FAIL valid_early: got %b on rvalid cycle, required 0", data_valid);
        @(negedge clk);
        checks++;
        if (data_valid === 1'b1 && data === pat(11, 0)) passes++;
        else $display("FAIL stream_start: valid=%b data=%h, required 1 %h", data_valid, data, pat(11, 0));
        wait_idle(300);
        lat = 2;
    endtask

    task automatic test_reset_mid();
        int q[$];
        int n;
        q = {2, 6};
        set_blk(2, 6, 1'b0);
        set_blk(6, 0, 1'b1);
        beats_seen = 0;
        push_frame(q);
        start_frame(2);
        n = 0;
        while (beats_seen < 92 && n < 500) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (beats_seen == 92 && data_valid === 1'b1 && data === pat(6, 30)) passes++;
        else $display("FAIL pre_abort: beats=%0d data=%h, required 92 %h", beats_seen, data, pat(6, 30));
        rst = 1'b1;
        #1;
        checks++;
        if ({frame_ready, mem_re, mem_addr, data, data_valid, data_begin, data_end, fl_free_req, fl_free_idx} === '0) passes++;
        else $display("FAIL abort_outputs: valid=%b end=%b free=%b ready=%b, required all 0",
                      data_valid, data_end, fl_free_req, frame_ready);
        exp_beats.delete();
        exp_rd.delete();
        exp_fr.delete();
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (fl_free_req === 1'b0 && data_end === 1'b0) passes++;
            else $display("FAIL abort_pulses: free=%b end=%b, required 0 0", fl_free_req, data_end);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        q = {5};
        beats_seen = 0;
        push_frame(q);
        start_frame(5);
        wait_idle(300);
        checks++;
        if (beats_seen == 62) passes++;
        else $display("FAIL after_abort_beats: got %0d, required 62", beats_seen);
    endtask

    task automatic test_block_gap();
        int q[$];
        int gap, want;
        q = {8, 10};
        set_blk(8, 10, 1'b0);
        set_blk(10, 0, 1'b1);
        lat        = 3;
        beats_seen = 0;
        push_frame(q);
        start_frame(8);
        wait_idle(500);
        gap = beat_cyc[62] - beat_cyc[61];
`ifdef MEM_RD_PREFETCH_EN
        want = 1;
`else
        want = 2 + 3;
`endif
        checks++;
        if (beats_seen == 124 && gap == want) passes++;
        else $display("FAIL block_gap: beats=%0d gap=%0d, required 124 %0d", beats_seen, gap, want);
        lat = 2;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_chain();
        test_backpressure();
        test_mem_stall();
        test_reset_mid();
        test_block_gap();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
